fake_netlist_bist: RTL and testbench

Self-test harness for the generated combinational netlists: drives a netlist's primary inputs with an LFSR pseudo-random pattern stream and compacts its outputs into a MISR signature. It sits on the opposite side of a netlist's port list from the netlist itself. It is instantiated around a netlist in equivalence and regression benches, and around the mapped gate-level result after synthesis, so the two signatures can be compared.

---
 rtl/fake_netlist_bist.sv | 145 ++++++++++++++
 tb/tb_fake_netlist_bist.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fake_netlist_bist.sv
// LFSR pattern generator and MISR response compactor wrapped around a combinational netlist.
// Define BIST_RESP_REG_EN to register resp_i and add a one-cycle DRAIN state.
module fake_netlist_bist #(
    parameter int          N_IN      = 10,
    parameter int          N_OUT     = 1,
    parameter int          PATTERNS  = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] SIG_SEED  = 16'h0000,
    localparam int         CW        = $clog2(PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  pattern_o,
    input  logic [N_OUT-1:0] resp_i,
    output logic [15:0]      signature_o,
    output logic [CW-1:0]    pat_count_o
);

    localparam logic [CW-1:0] PAT_MAX  = CW'(PATTERNS);
    localparam logic [CW-1:0] PAT_LAST = CW'(PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0]       sig_q, sig_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_OUT-1:0]  cap;
    logic [15:0]       cap_ext;
    logic              cap_en;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
    endfunction

`ifdef BIST_RESP_REG_EN
    logic [N_OUT-1:0] resp_q, resp_d;

    always_comb begin
        resp_d = resp_i;
    end

    // The MISR sees the response one cycle late, so capture lags the pattern index by one.
    always_comb begin
        cap = resp_q;
    end
`else
    always_comb begin
        cap = resp_i;
    end
`endif

    always_comb begin
        cap_ext             = '0;
        cap_ext[N_OUT-1:0]  = cap;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d  = LFSR_SEED;
                    sig_d   = SIG_SEED;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q != PAT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef BIST_RESP_REG_EN
                cap_en = (cnt_q != '0);
                if (cnt_q == PAT_LAST) begin
                    state_d = S_DRAIN;
                end
`else
                cap_en = 1'b1;
                if (cnt_q == PAT_LAST) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_DRAIN: begin
                cap_en  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // start in IDLE/DONE reloads sig_d above and never coincides with a capture.
        if (cap_en) begin
            sig_d = misr_step(sig_q, cap_ext);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            sig_q   <= SIG_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BIST_RESP_REG_EN
    // NOTE: the response pipeline register carries pure data and is skipped on its first use, so it needs no reset.
    always_ff @(posedge clk) begin
        resp_q <= resp_d;
    end
`endif

    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign pattern_o   = lfsr_q[N_IN-1:0];
    assign signature_o = sig_q;
    assign pat_count_o = cnt_q;

endmodule

// File: tb/tb_fake_netlist_bist.sv
// Directed bench for fake_netlist_bist: a 256-pattern parity netlist and a 1-pattern instance.
module tb_fake_netlist_bist;

`ifdef BIST_RESP_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_a = 1'b0;
    logic        busy_a, done_a;
    logic [9:0]  pat_a;
    logic [0:0]  resp_a;
    logic [15:0] sig_a;
    logic [8:0]  cnt_a;
    logic        fault_en = 1'b0;

    logic        start_b = 1'b0;
    logic        busy_b, done_b;
    logic [9:0]  pat_b;
    logic [0:0]  resp_b = 1'b0;
    logic [15:0] sig_b;
    logic [0:0]  cnt_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Netlist under test: output parity of the inputs, with an optional single stuck fault.
    assign resp_a[0] = (^pat_a) ^ (fault_en && (pat_a == 10'h0E1));

    fake_netlist_bist #(
        .N_IN(10), .N_OUT(1), .PATTERNS(256), .LFSR_SEED(16'hACE1), .SIG_SEED(16'h0000)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pattern_o(pat_a), .resp_i(resp_a), .signature_o(sig_a), .pat_count_o(cnt_a)
    );

    fake_netlist_bist #(
        .N_IN(10), .N_OUT(1), .PATTERNS(1), .LFSR_SEED(16'hACE1), .SIG_SEED(16'h0000)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pattern_o(pat_b), .resp_i(resp_b), .signature_o(sig_b), .pat_count_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run dut_a to completion from its first RUN cycle; optionally pulse start at a given RUN cycle.
    task automatic run_a(input int pulse_at, output int cyc);
        cyc = 0;
        while (busy_a && cyc < 2000) begin
            if (cyc == pulse_at) start_a = 1'b1;
            step();
            start_a = 1'b0;
            cyc++;
        end
    endtask

    function automatic logic [15:0] model_sig(input bit fault);
        logic [15:0] lfsr;
        logic [15:0] sig;
        logic [9:0]  pat;
        logic        r;
        lfsr = 16'hACE1;
        sig  = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            pat  = lfsr[9:0];
            r    = (^pat) ^ (fault && (pat == 10'h0E1));
            sig  = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
            lfsr = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
        return sig;
    endfunction

    initial begin
        int          cyc;
        int          done_seen;
        logic [15:0] good_sig;
        logic [15:0] bad_sig;
        good_sig = model_sig(1'b0);
        bad_sig  = model_sig(1'b1);

        // Reset then idle
        repeat (2) step();
        rst = 1'b0;
        step();
        check("idle_pattern", pat_a, 10'h0E1);
        check("idle_sig", sig_a, 16'h0000);
        check("idle_busy", busy_a, 0);
        check("idle_done", done_a, 0);
        check("idle_count", cnt_a, 0);

        // Full run with a dropped mid-run start
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("run0_busy", busy_a, 1);
        check("run0_pattern", pat_a, 10'h0E1);
        check("run0_count", cnt_a, 0);
        step();
        check("run1_pattern", pat_a, 10'h270);
        check("run1_count", cnt_a, 1);
        run_a(50, cyc);
        check("run_len", cyc + 1, 256 + EXTRA);
        check("run_done", done_a, 1);
        check("run_count", cnt_a, 256);
        check("run_sig", sig_a, good_sig);
        repeat (5) step();
        check("done_held", done_a, 1);
        check("done_sig_frozen", sig_a, good_sig);

        // Restart from DONE
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("restart_done_drop", done_a, 0);
        check("restart_busy", busy_a, 1);
        check("restart_count", cnt_a, 0);
        run_a(-1, cyc);
        check("restart_len", cyc, 256 + EXTRA);
        check("restart_sig", sig_a, good_sig);

        // Faulty netlist gives the faulty model signature, distinct from the good one
        fault_en = 1'b1;
        start_a  = 1'b1;
        step();
        start_a  = 1'b0;
        run_a(-1, cyc);
        check("fault_sig", sig_a, bad_sig);
        check("fault_differs", sig_a != good_sig, 1);
        fault_en = 1'b0;

        // Reset mid-run aborts without done
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (100) step();
        check("abort_pre_count", cnt_a, 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_sig", sig_a, 16'h0000);
        check("abort_count", cnt_a, 0);
        check("abort_pattern", pat_a, 10'h0E1);
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_a) done_seen++;
            step();
        end
        check("abort_no_done", done_seen, 0);

        // Reset wins over a simultaneous start
        rst     = 1'b1;
        start_a = 1'b1;
        step();
        rst     = 1'b0;
        start_a = 1'b0;
        check("rst_over_start", busy_a, 0);

        // PATTERNS = 1 with response 1
        resp_b  = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 20) begin
            step();
            cyc++;
        end
        check("p1_busy_len", cyc, 1 + EXTRA);
        check("p1_done", done_b, 1);
        check("p1_sig", sig_b, 16'h0001);
        check("p1_count", cnt_b, 1);

        // PATTERNS = 1 with response 0, restarted from DONE
        resp_b  = 1'b0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (1 + EXTRA) step();
        check("p1z_done", done_b, 1);
        check("p1z_sig", sig_b, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
